reaction_ctrl: RTL

REACTION_CTRL -- requirements
Module: reaction_ctrl

---
 rtl/reaction_pkg.sv | 27 ++
 rtl/reaction_ms_tick_gen.sv | 42 ++++
 rtl/reaction_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/reaction_pkg.sv
// reaction_pkg: shared types and constants for the reaction-time game.
// Holds the controller state enum, LED display patterns and default counter width.
package reaction_pkg;

  // Default width of the delay, wait and reaction-time counters.
  localparam int CNT_W_DEF = 11;

  // LED display patterns.
  localparam logic [9:0] LED_OFF  = 10'h000;
  localparam logic [9:0] LED_GO   = 10'h3FF;
  localparam logic [9:0] LED_FOUL = 10'b1010101010;

  // Controller states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_GO   = 3'd2,
    ST_DONE = 3'd3,
    ST_FOUL = 3'd4
  } state_e;

  // A trial is in progress while waiting for GO or timing the response.
  function automatic logic is_busy(input state_e s);
    return (s == ST_WAIT) || (s == ST_GO);
  endfunction

endpackage

// File: rtl/reaction_ms_tick_gen.sv
// ms_tick_gen: millisecond prescaler. Counts 0..MS_DIV-1 while enabled and
// pulses tick for one cycle on the last count, then wraps. A synchronous clear
// restarts the count so every state begins with a full millisecond.
module ms_tick_gen #(
  parameter int MS_DIV = 50000
) (
  input  logic CLK,
  input  logic RESETN,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(MS_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // The tick is seen by the controller in the same cycle it causes a state change.
  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap while enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: reaction-time game controller.
// start arms a trial, a randomless programmable delay elapses (WAIT), then the
// LEDs light (GO) and the ms counter runs until the player reacts or it saturates.
// Optional feature: define REACTION_BEST_EN to add a best-time output register.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int MS_DIV = 50000,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             start_btn,
  input  logic             react_btn,
  input  logic [CNT_W-1:0] delay,
  output logic [9:0]       LED,
  output logic [CNT_W-1:0] t,
  output logic             busy,
  output logic             done,
  output logic             foul
`ifdef REACTION_BEST_EN
  ,
  output logic [CNT_W-1:0] best
`endif
);

  // Largest value t takes before its final increment to all ones.
  localparam logic [CNT_W-1:0] T_LAST = CNT_W'((1 << CNT_W) - 2);

  state_e state_q, state_d;

  // Buttons packed as {react, start}.
  logic [1:0] btn;
  logic [1:0] btn_q;
  logic [1:0] arm_q;
  logic [1:0] btn_ev;
  logic       start_ev;
  logic       react_ev;

  logic [CNT_W-1:0] dly_q, dly_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] t_q, t_d;

  logic       tick;
  logic       tick_en;
  logic       tick_clr;

  logic [9:0] t_led;
  logic [9:0] led_d;
  logic       busy_d;
  logic       done_d;
  logic       foul_d;

  assign btn = {react_btn, start_btn};

  // Edge capture. arm_q only sets once a button has been seen low, so a button
  // held through reset release cannot fire an event until it is re-pressed.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      btn_q <= '0;
      arm_q <= '0;
    end else begin
      btn_q <= btn;
      arm_q <= arm_q | ~btn;
    end
  end

  assign btn_ev   = btn & ~btn_q & arm_q;
  assign start_ev = btn_ev[0];
  assign react_ev = btn_ev[1];

  // Prescaler runs only during a trial and restarts on every state change.
  assign tick_en  = is_busy(state_q);
  assign tick_clr = (state_d != state_q);

  ms_tick_gen #(
    .MS_DIV (MS_DIV)
  ) u_tick (
    .CLK    (CLK),
    .RESETN (RESETN),
    .en     (tick_en),
    .clr    (tick_clr),
    .tick   (tick)
  );

  // State and trial datapath registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      dly_q   <= '0;
      wcnt_q  <= '0;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      wcnt_q  <= wcnt_d;
      t_q     <= t_d;
    end
  end

  // Next state and datapath. React beats a coincident tick in both WAIT and GO.
  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    wcnt_d  = wcnt_q;
    t_d     = t_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_FOUL: begin
        if (start_ev) begin
          state_d = ST_WAIT;
          dly_d   = (delay == '0) ? CNT_W'(1) : delay;
          wcnt_d  = '0;
          t_d     = '0;
        end
      end
      ST_WAIT: begin
        if (react_ev) begin
          state_d = ST_FOUL;
          t_d     = '0;
        end else if (tick) begin
          if (wcnt_q == dly_q - 1'b1) begin
            state_d = ST_GO;
          end else begin
            wcnt_d = wcnt_q + 1'b1;
          end
        end
      end
      ST_GO: begin
        if (react_ev) begin
          state_d = ST_DONE;
        end else if (tick) begin
          t_d = t_q + 1'b1;
          if (t_q == T_LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Low ten bits of the result, zero-filled when the counter is narrower.
  for (genvar gi = 0; gi < 10; gi++) begin : g_t_led
    if (gi < CNT_W) begin : g_bit
      assign t_led[gi] = t_d[gi];
    end else begin : g_zero
      assign t_led[gi] = 1'b0;
    end
  end

  // Output decode from the upcoming state so registered outputs align with it.
  always_comb begin
    busy_d = is_busy(state_d);
    done_d = 1'b0;
    foul_d = 1'b0;
    led_d  = LED_OFF;
    case (state_d)
      ST_GO:   led_d = LED_GO;
      ST_DONE: begin
        done_d = 1'b1;
        led_d  = t_led;
      end
      ST_FOUL: begin
        foul_d = 1'b1;
        led_d  = LED_FOUL;
      end
      default: led_d = LED_OFF;
    endcase
  end

  // Registered status and display outputs.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      LED  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      foul <= 1'b0;
    end else begin
      LED  <= led_d;
      busy <= busy_d;
      done <= done_d;
      foul <= foul_d;
    end
  end

  assign t = t_q;

`ifdef REACTION_BEST_EN
  logic [CNT_W-1:0] best_q;

  // Best time tracks only player-ended trials; a timeout never reaches here.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      best_q <= '1;
    end else if ((state_q == ST_GO) && react_ev && (t_q < best_q)) begin
      best_q <= t_q;
    end
  end

  assign best = best_q;
`endif

endmodule
